des_key_sched_iter: RTL and testbench
=====================================

Name: des_key_sched_iter

Overview:
- Iterative DES key scheduler for the area-optimised (single-round, looped) datapath; a round-serial alternative to the unrolled per-round key generator chain.
- Accepts a 64-bit DES key over a valid/ready handshake and applies PC-1 (64->56).
- Generates the 16 round keys serially, one per cycle: per-round C/D left rotation, then PC-2 (56->48).
- Stores the round keys in a 16x48 register file, which the downstream round engine reads by round index in encrypt or decrypt order.

Parameters:
- NUM_ROUNDS, 16, number of round keys generated and stored; only 16 is supported, and any other value is a build-time error.
- RD_REG, 1, 1 = registered read port (1-cycle read latency); 0 = combinational read.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- key_i  input  64  DES key; bit 63 = DES bit 1, including parity bits.
- key_valid_i  input  1  key_i valid.
- key_ready_o  output  1  block can accept a key.
- decrypt_i  input  1  read order: 0 = K1..K16, 1 = K16..K1.
- rk_idx_i  input  4  round index requested, 0..15.
- rk_o  output  48  round key for rk_idx_i.
- sched_done_o  output  1  all 16 keys valid in store.
- busy_o  output  1  generation in progress.
- key_err_o  output  1  parity error on last offered key; only meaningful with PARITY_CHECK_EN.

Behaviour:
- Reset values: FSM=IDLE, C/D regs=0, all 16 store entries=0, rk_o=0, sched_done_o=0, busy_o=0, key_err_o=0, key_ready_o=1.
- Reset asserted mid-generation aborts immediately; the store is cleared.
- FSM states: IDLE, GEN, DONE.
- IDLE: key_ready_o=1. Accept occurs when key_valid_i && key_ready_o. On accept: C/D <= PC-1(key_i), round counter <= 0, go to GEN.
- GEN: key_ready_o=0, busy_o=1, sched_done_o=0. Each cycle with round counter r (0..15):
  - shift amount = 1 for r in {0,1,8,15}, else 2;
  - C and D (28 bits each) rotate left independently;
  - store[r] <= PC-2({C',D'}) and C/D <= {C',D'};
  - counter increments; after r=15, go to DONE.
- Latency: key accepted on edge 0; store[0..15] written on edges 1..16; sched_done_o=1 from edge 16, i.e. 16 cycles after accept.
- After 16 rounds the C/D regs equal the PC-1 value again (total rotation 28). This is checked by an assertion.
- DONE: sched_done_o=1, key_ready_o=1. A new accept clears sched_done_o on the same edge and re-enters GEN; the store is overwritten progressively.
- Key offered while in GEN is not accepted: ready=0, and the source holds it.
- Read port, physical index = decrypt_i ? 15-rk_idx_i : rk_idx_i.
  - RD_REG=1: rk_o updates on the next edge.
  - RD_REG=0: rk_o is combinational.
- Reads during GEN return the current store contents, which may be stale or partial. The consumer gates on sched_done_o.
- Width rules: permutations are pure bit selection; no arithmetic. The round counter is 4 bits and never wraps within GEN.

Optional Feature:
- Macro: DES_KEY_PARITY_CHECK_EN.
- Defined:
  - each key byte must have odd parity;
  - on a valid offer with any even-parity byte, the key is accepted (handshake completes) but discarded: FSM stays in its current IDLE/DONE state and the store is unchanged;
  - key_err_o=1 until the next accepted key with good parity, which clears it on the accept edge.
- Undefined: parity bits are ignored (dropped by PC-1); key_err_o is tied 0.

Test Plan:
- Key 0x133457799BBCDFF1, decrypt_i=0, after sched_done_o -> PC-1 snapshot on accept = 0xF0CCAAF556678F; rk_idx 0 -> rk_o=0x1B02EFFC7072; rk_idx 15 -> 0xCB3D8B0E17F5; sched_done_o rises exactly 16 cycles after accept.
- Same key, decrypt_i=1 -> rk_idx 0 returns 0xCB3D8B0E17F5 and rk_idx 15 returns 0x1B02EFFC7072; with RD_REG=1, 1-cycle read latency is verified.
- Key 0x0101010101010101 (weak key) -> all 16 round keys = 0x000000000000; C/D return to the PC-1 value after round 16.
- Second key held valid during GEN -> key_ready_o=0 for 16 cycles, then accepted in DONE; sched_done_o drops on that edge and K1 of the new key appears in store[0] one edge later.
- rstn pulled low at round 7 -> all outputs reset asynchronously (no clock edge needed); key_ready_o=1 after release; the store reads 0.
- With DES_KEY_PARITY_CHECK_EN, key 0x133457799BBCDFF0 -> key_err_o=1, store and sched_done_o unchanged; then 0x133457799BBCDFF1 -> key_err_o=0 and normal schedule.

Source files
------------

// File: rtl/des_key_sched_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : des_key_sched_iter                                             |
// | Purpose : Iterative DES key scheduler. Accepts a 64-bit key, applies     |
// |           PC-1, then produces one round key per cycle (C/D rotate, PC-2) |
// |           into a 16x48 store that is read by round index in encrypt or   |
// |           decrypt order.                                                 |
// | Params  : NUM_ROUNDS (must be 16), RD_REG (1 = registered read port,     |
// |           0 = combinational read)                                        |
// | Macro   : DES_KEY_PARITY_CHECK_EN - when defined, keys with any          |
// |           even-parity byte are handshaken but discarded and flag         |
// |           key_err_o; when undefined, parity bits are ignored.            |
// | Ports   : clk          in   system clock, rising edge                    |
// |           rstn         in   asynchronous active-low reset                |
// |           key_i        in   [63:0] key, bit 63 = DES bit 1               |
// |           key_valid_i  in   key_i valid                                  |
// |           key_ready_o  out  block can accept a key                       |
// |           decrypt_i    in   read order: 0 = K1..K16, 1 = K16..K1         |
// |           rk_idx_i     in   [3:0] round index requested                  |
// |           rk_o         out  [47:0] round key for rk_idx_i                |
// |           sched_done_o out  all 16 round keys valid in store             |
// |           busy_o       out  generation in progress                       |
// |           key_err_o    out  parity error on last offered key             |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module des_key_sched_iter #(
   parameter int NUM_ROUNDS = 16,
   parameter int RD_REG     = 1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [63:0] key_i,
   input  logic        key_valid_i,
   output logic        key_ready_o,
   input  logic        decrypt_i,
   input  logic [3:0]  rk_idx_i,
   output logic [47:0] rk_o,
   output logic        sched_done_o,
   output logic        busy_o,
   output logic        key_err_o
);

   // The datapath, counter width and store depth are built for exactly 16 rounds.
   generate
      if (NUM_ROUNDS != 16) begin : g_bad_rounds
         $error("des_key_sched_iter: NUM_ROUNDS must be 16");
      end
   endgenerate

   // Permutation tables, one byte per entry, first table entry in the top byte.
   // Entries are 1-based DES bit positions (bit 1 = MSB of the source vector).
   localparam logic [8*56-1:0] c_PC1_TBL = {
      8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,
      8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18, 8'd10, 8'd2,
      8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,
      8'd60, 8'd52, 8'd44, 8'd36, 8'd63, 8'd55, 8'd47, 8'd39,
      8'd31, 8'd23, 8'd15, 8'd7,  8'd62, 8'd54, 8'd46, 8'd38,
      8'd30, 8'd22, 8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37,
      8'd29, 8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4
   };

   localparam logic [8*48-1:0] c_PC2_TBL = {
      8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,  8'd3,  8'd28,
      8'd15, 8'd6,  8'd21, 8'd10, 8'd23, 8'd19, 8'd12, 8'd4,
      8'd26, 8'd8,  8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
      8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55, 8'd30, 8'd40,
      8'd51, 8'd45, 8'd33, 8'd48, 8'd44, 8'd49, 8'd39, 8'd56,
      8'd34, 8'd53, 8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32
   };

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_GEN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   logic [27:0] r_c;
   logic [27:0] r_d;
   logic [3:0]  r_round;
   logic        r_key_ready;
   logic        r_busy;
   logic        r_done;
   logic [47:0] r_store [16];

   logic [55:0] w_pc1;
   logic [27:0] w_c_nxt;
   logic [27:0] w_d_nxt;
   logic [55:0] w_cd_nxt;
   logic [47:0] w_pc2;
   logic        w_shift2;
   logic        w_par_ok;
   logic        w_accept;
   logic [3:0]  w_phys_idx;

   // PC-1: 64 -> 56, drops the eight parity bits.
   generate
      for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
         localparam logic [5:0] c_SRC = 6'(64 - int'(c_PC1_TBL[8*(55-gi) +: 8]));
         assign w_pc1[55-gi] = key_i[c_SRC];
      end
   endgenerate

   // Rounds 1, 2, 9 and 16 rotate by one, all others by two (28 in total).
   always_comb begin
      w_shift2 = 1'b1;
      case (r_round)
         4'd0, 4'd1, 4'd8, 4'd15: w_shift2 = 1'b0;
         default:                 w_shift2 = 1'b1;
      endcase
   end

   assign w_c_nxt  = w_shift2 ? {r_c[25:0], r_c[27:26]} : {r_c[26:0], r_c[27]};
   assign w_d_nxt  = w_shift2 ? {r_d[25:0], r_d[27:26]} : {r_d[26:0], r_d[27]};
   assign w_cd_nxt = {w_c_nxt, w_d_nxt};

   // PC-2: 56 -> 48 on the freshly rotated C/D.
   generate
      for (genvar gk = 0; gk < 48; gk++) begin : g_pc2
         localparam logic [5:0] c_SRC = 6'(56 - int'(c_PC2_TBL[8*(47-gk) +: 8]));
         assign w_pc2[47-gk] = w_cd_nxt[c_SRC];
      end
   endgenerate

`ifdef DES_KEY_PARITY_CHECK_EN
   logic [7:0] w_byte_odd;
   logic       r_key_err;

   generate
      for (genvar gb = 0; gb < 8; gb++) begin : g_parity
         assign w_byte_odd[gb] = ^key_i[8*gb +: 8];
      end
   endgenerate

   assign w_par_ok = &w_byte_odd;

   // Every completed handshake updates the flag, good or bad.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_key_err <= 1'b0;
      end else if (key_valid_i && r_key_ready) begin
         r_key_err <= ~w_par_ok;
      end
   end

   assign key_err_o = r_key_err;
`else
   logic w_unused_parity;

   assign w_par_ok        = 1'b1;
   assign key_err_o       = 1'b0;
   assign w_unused_parity = ^{key_i[56], key_i[48], key_i[40], key_i[32],
                              key_i[24], key_i[16], key_i[8],  key_i[0]};
`endif

   // A bad-parity key still completes the handshake but never starts a schedule.
   assign w_accept = key_valid_i && r_key_ready && w_par_ok;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= S_IDLE;
         r_c         <= '0;
         r_d         <= '0;
         r_round     <= '0;
         r_key_ready <= 1'b1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            r_store[i] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_accept) begin
                  r_c         <= w_pc1[55:28];
                  r_d         <= w_pc1[27:0];
                  r_round     <= 4'd0;
                  r_state     <= S_GEN;
                  r_key_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  r_done      <= 1'b0;
               end
            end
            S_GEN: begin
               r_c              <= w_c_nxt;
               r_d              <= w_d_nxt;
               r_store[r_round] <= w_pc2;
               r_round          <= r_round + 4'd1;
               if (r_round == 4'd15) begin
                  r_state     <= S_DONE;
                  r_key_ready <= 1'b1;
                  r_busy      <= 1'b0;
                  r_done      <= 1'b1;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_key_ready <= 1'b1;
               r_busy      <= 1'b0;
               r_done      <= 1'b0;
            end
         endcase
      end
   end

   assign key_ready_o  = r_key_ready;
   assign busy_o       = r_busy;
   assign sched_done_o = r_done;

   // Decrypt order reverses the index; 15 - idx is the bitwise inverse for 4 bits.
   assign w_phys_idx = decrypt_i ? ~rk_idx_i : rk_idx_i;

   generate
      if (RD_REG != 0) begin : g_rd_reg
         logic [47:0] r_rk;
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               r_rk <= '0;
            end else begin
               r_rk <= r_store[w_phys_idx];
            end
         end
         assign rk_o = r_rk;
      end else begin : g_rd_comb
         assign rk_o = r_store[w_phys_idx];
      end
   endgenerate

`ifndef SYNTHESIS
   // The rotations sum to 28, so the final C/D must equal the PC-1 snapshot.
   logic [55:0] r_pc1_snap;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pc1_snap <= '0;
      end else begin
         if (w_accept) begin
            r_pc1_snap <= w_pc1;
         end
         if ((r_state == S_GEN) && (r_round == 4'd15)) begin
            assert (w_cd_nxt == r_pc1_snap)
               else $error("des_key_sched_iter: C/D did not return to PC-1 value");
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_des_key_sched_iter.sv
`default_nettype none
module tb_des_key_sched_iter;

   localparam int RD_REG = 1;

   localparam int PC1_T [56] = '{
      57, 49, 41, 33, 25, 17, 9,  1,  58, 50, 42, 34, 26, 18,
      10, 2,  59, 51, 43, 35, 27, 19, 11, 3,  60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15, 7,  62, 54, 46, 38, 30, 22,
      14, 6,  61, 53, 45, 37, 29, 21, 13, 5,  28, 20, 12, 4};

   localparam int PC2_T [48] = '{
      14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10,
      23, 19, 12, 4,  26, 8,  16, 7,  27, 20, 13, 2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
   localparam logic [63:0] KEY_BAD = 64'h133457799BBCDFF0;
   localparam logic [63:0] KEY_W   = 64'h0101010101010101;
   localparam logic [63:0] KEY_B   = 64'h0123456789ABCDEF;

   logic        clk;
   logic        rstn;
   logic [63:0] key_i;
   logic        key_valid_i;
   logic        key_ready_o;
   logic        decrypt_i;
   logic [3:0]  rk_idx_i;
   logic [47:0] rk_o;
   logic        sched_done_o;
   logic        busy_o;
   logic        key_err_o;

   int n_checks = 0;
   int n_fail   = 0;

   des_key_sched_iter #(.NUM_ROUNDS(16), .RD_REG(RD_REG)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .key_i        (key_i),
      .key_valid_i  (key_valid_i),
      .key_ready_o  (key_ready_o),
      .decrypt_i    (decrypt_i),
      .rk_idx_i     (rk_idx_i),
      .rk_o         (rk_o),
      .sched_done_o (sched_done_o),
      .busy_o       (busy_o),
      .key_err_o    (key_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference functions ----------------
   function automatic logic [55:0] f_pc1(input logic [63:0] k);
      logic [55:0] r;
      r = '0;
      for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1_T[i]];
      return r;
   endfunction

   function automatic logic [27:0] f_rotl(input logic [27:0] x, input int s);
      logic [55:0] d;
      d = {x, x};
      d = d >> (28 - s);
      return d[27:0];
   endfunction

   // Round key r (0-based) straight from the cumulative rotation amount.
   function automatic logic [47:0] f_rk(input logic [63:0] k, input int r);
      logic [55:0] cd;
      logic [55:0] rot;
      logic [47:0] o;
      int          s;
      cd = f_pc1(k);
      s  = 0;
      for (int j = 0; j <= r; j++) s += SHIFT_T[j];
      rot = {f_rotl(cd[55:28], s), f_rotl(cd[27:0], s)};
      o = '0;
      for (int i = 0; i < 48; i++) o[47-i] = rot[56-PC2_T[i]];
      return o;
   endfunction

   function automatic bit f_par_ok(input logic [63:0] k);
      for (int b = 0; b < 8; b++) begin
         if (($countones(k[8*b +: 8]) % 2) == 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic int f_phys(input logic [3:0] idx, input logic dec);
      return dec ? (15 - int'(idx)) : int'(idx);
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [47:0] m_store [16];
   logic [63:0] m_key;
   bit          m_gen;
   int          m_step;
   bit          m_done;
   bit          m_err;
   logic [47:0] m_rk;
   logic [47:0] m_rd_tmp;
   bit          m_ok;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < 16; i++) m_store[i] = '0;
         m_key  = '0;
         m_gen  = 0;
         m_step = 0;
         m_done = 0;
         m_err  = 0;
         m_rk   = '0;
      end else begin
         m_rd_tmp = m_store[f_phys(rk_idx_i, decrypt_i)];
         if (m_gen) begin
            m_store[m_step] = f_rk(m_key, m_step);
            m_step++;
            if (m_step == 16) begin
               m_gen  = 0;
               m_done = 1;
            end
         end else if (key_valid_i) begin
            m_ok = 1;
`ifdef DES_KEY_PARITY_CHECK_EN
            m_ok = f_par_ok(key_i);
`endif
            if (m_ok) begin
               m_key  = key_i;
               m_gen  = 1;
               m_step = 0;
               m_done = 0;
               m_err  = 0;
            end else begin
               m_err = 1;
            end
         end
         m_rk = m_rd_tmp;
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      logic [47:0] exp_rk;
      exp_rk = (RD_REG != 0) ? m_rk : m_store[f_phys(rk_idx_i, decrypt_i)];
      check("cyc_rk_o",     rk_o,         exp_rk);
      check("cyc_ready",    key_ready_o,  !m_gen);
      check("cyc_busy",     busy_o,       m_gen);
      check("cyc_done",     sched_done_o, m_done);
      check("cyc_key_err",  key_err_o,    m_err);
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer_and_wait(input logic [63:0] k, output int lat);
      key_i       = k;
      key_valid_i = 1'b1;
      tick();
      key_valid_i = 1'b0;
      lat = -1;
      for (int n = 1; n <= 24; n++) begin
         tick();
         if (sched_done_o) begin
            lat = n;
            break;
         end
      end
   endtask

   initial begin
      int lat;
      int low;

      rstn        = 1'b1;
      key_i       = '0;
      key_valid_i = 1'b0;
      decrypt_i   = 1'b0;
      rk_idx_i    = 4'd0;
      #2 rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", key_ready_o,  1'b1);
      check("rst_done",  sched_done_o, 1'b0);
      check("rst_busy",  busy_o,       1'b0);
      check("rst_rk",    rk_o,         48'h0);
      check("rst_err",   key_err_o,    1'b0);
      rstn = 1'b1;
      tick();

      // Model pinned against known DES reference values.
      check("model_pc1", f_pc1(KEY_A),   56'hF0CCAAF556678F);
      check("model_k1",  f_rk(KEY_A, 0), 48'h1B02EFFC7072);
      check("model_k16", f_rk(KEY_A, 15), 48'hCB3D8B0E17F5);

      // Encrypt-order schedule and latency.
      offer_and_wait(KEY_A, lat);
      check("latency_A", lat, 16);
      check("cd_back_A", {dut.r_c, dut.r_d}, 56'hF0CCAAF556678F);
      rk_idx_i = 4'd0;
      tick();
      check("enc_idx0", rk_o, 48'h1B02EFFC7072);
      rk_idx_i = 4'd15;
      check("rd_latency_hold", rk_o, 48'h1B02EFFC7072);
      tick();
      check("enc_idx15", rk_o, 48'hCB3D8B0E17F5);

      // Decrypt order.
      decrypt_i = 1'b1;
      rk_idx_i  = 4'd0;
      tick();
      check("dec_idx0", rk_o, 48'hCB3D8B0E17F5);
      rk_idx_i = 4'd15;
      tick();
      check("dec_idx15", rk_o, 48'h1B02EFFC7072);
      decrypt_i = 1'b0;

      // Weak key: every round key is zero and C/D stays at PC-1.
      offer_and_wait(KEY_W, lat);
      check("latency_W", lat, 16);
      check("cd_back_W", {dut.r_c, dut.r_d}, f_pc1(KEY_W));
      for (int r = 0; r < 16; r++) begin
         rk_idx_i = 4'(r);
         tick();
         check("weak_rk", rk_o, 48'h0);
      end

      // Key held valid through GEN, accepted only once back in DONE.
      key_i       = KEY_A;
      key_valid_i = 1'b1;
      tick();
      key_i = KEY_B;
      low   = 0;
      for (int n = 0; n < 40; n++) begin
         if (key_ready_o) break;
         low++;
         tick();
      end
      check("ready_low_cycles", low, 16);
      check("held_done_before", sched_done_o, 1'b1);
      rk_idx_i = 4'd0;
      tick();
      check("held_done_drop", sched_done_o, 1'b0);
      check("held_busy",      busy_o,       1'b1);
      key_valid_i = 1'b0;
      tick();
      check("held_old_k1", rk_o, f_rk(KEY_A, 0));
      tick();
      check("held_new_k1", rk_o, f_rk(KEY_B, 0));
      lat = -1;
      for (int n = 0; n < 24; n++) begin
         if (sched_done_o) begin
            lat = n;
            break;
         end
         tick();
      end
      check("held_done_seen", (lat >= 0), 1'b1);

      // Asynchronous reset in the middle of generation.
      rk_idx_i    = 4'd3;
      key_i       = KEY_A;
      key_valid_i = 1'b1;
      tick();
      key_valid_i = 1'b0;
      repeat (7) tick();
      check("mid_busy", busy_o, 1'b1);
      #2 rstn = 1'b0;
      #1;
      check("arst_ready", key_ready_o,  1'b1);
      check("arst_done",  sched_done_o, 1'b0);
      check("arst_busy",  busy_o,       1'b0);
      check("arst_rk",    rk_o,         48'h0);
      @(posedge clk);
      #1 rstn = 1'b1;
      check("post_rst_ready", key_ready_o, 1'b1);
      for (int r = 0; r < 16; r++) begin
         rk_idx_i = 4'(r);
         tick();
         check("post_rst_store", rk_o, 48'h0);
      end

`ifdef DES_KEY_PARITY_CHECK_EN
      check("model_par_bad", f_par_ok(KEY_BAD), 1'b0);
      offer_and_wait(KEY_A, lat);
      check("latency_par", lat, 16);
      key_i       = KEY_BAD;
      key_valid_i = 1'b1;
      tick();
      key_valid_i = 1'b0;
      check("bad_err",   key_err_o,    1'b1);
      check("bad_done",  sched_done_o, 1'b1);
      check("bad_busy",  busy_o,       1'b0);
      rk_idx_i = 4'd0;
      repeat (3) tick();
      check("bad_store", rk_o, 48'h1B02EFFC7072);
      check("bad_err_hold", key_err_o, 1'b1);
      key_i       = KEY_A;
      key_valid_i = 1'b1;
      tick();
      key_valid_i = 1'b0;
      check("good_err_clr", key_err_o,    1'b0);
      check("good_busy",    busy_o,       1'b1);
      lat = -1;
      for (int n = 0; n < 24; n++) begin
         if (sched_done_o) begin
            lat = n;
            break;
         end
         tick();
      end
      check("good_done_seen", (lat >= 0), 1'b1);
      rk_idx_i = 4'd15;
      tick();
      check("good_idx15", rk_o, 48'hCB3D8B0E17F5);
`else
      // Parity is ignored: this key differs from KEY_A only in a parity bit.
      offer_and_wait(KEY_BAD, lat);
      check("noparity_latency", lat, 16);
      check("noparity_err", key_err_o, 1'b0);
      rk_idx_i = 4'd15;
      tick();
      check("noparity_idx15", rk_o, 48'hCB3D8B0E17F5);
`endif

      repeat (2) tick();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
